// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: filter geometry, the 5x5 filter array type and the
// loader FSM state encoding.
package cnn_pkg;

  localparam int K     = 5;
  localparam int NELEM = K * K;

  typedef shortint filter5x5_t [K-1:0][K-1:0];

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    PRESENT,
    WAIT_ACK,
    RELEASE
  } loader_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that delays the memory-issue valid bit by the memory read latency,
// so a capture strobe emerges exactly when the matching read data is on the bus.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_in,
  output logic vld_out
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = vld_in;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign vld_out = vld_q[DEPTH-1];

endmodule

// File: rtl/filter_loader_5x5.sv
// Fetches K*K signed weights row-major from weight memory, assembles them into the
// KxK filter array and hands it to the filter buffer with a read/finish handshake.
module filter_loader_5x5
  import cnn_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [15:0]       mem_rdata,
  output logic                     read,
  input  logic                     finish,
  output filter5x5_t               output_filter,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = $clog2(NELEM);
  localparam int IDX_W = $clog2(K);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  col_q, col_d;
  filter5x5_t        filt_q, filt_d;
  logic              done_q, done_d;
  logic              cap_vld;
  logic              cap_last;

  valid_delay_line #(
    .DEPTH (MEM_LATENCY)
  ) u_vld_delay (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (mem_rd_en),
    .vld_out (cap_vld)
  );

  assign cap_last = cap_vld && (row_q == IDX_W'(K-1)) && (col_q == IDX_W'(K-1));

  // Capture side: write returning data at the (row, col) slot of the capture counter
  always_comb begin
    filt_d = filt_q;
    row_d  = row_q;
    col_d  = col_q;
    if (state_q == IDLE && start) begin
      row_d = '0;
      col_d = '0;
    end else if (cap_vld) begin
      filt_d[row_q][col_q] = mem_rdata;
      if (col_q == IDX_W'(K-1)) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    issue_d   = issue_q;
    done_d    = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    read      = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          base_d  = base_addr;
          issue_d = '0;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + ADDR_W'(issue_q);
        issue_d   = issue_q + CNT_W'(1);
        if (issue_q == CNT_W'(NELEM-1)) begin
          state_d = DRAIN;
          issue_d = '0;
        end
      end
      DRAIN: begin
        if (cap_last) state_d = PRESENT;
      end
      PRESENT: begin
        // A stale acknowledge from the previous hand-off must clear before read rises
        if (!finish) begin
          read    = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        read = 1'b1;
        if (finish) state_d = RELEASE;
      end
      RELEASE: begin
        if (!finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      filt_q  <= '{default: 16'sd0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      row_q   <= row_d;
      col_q   <= col_d;
      filt_q  <= filt_d;
      done_q  <= done_d;
    end
  end

  assign output_filter = filt_q;
  assign done          = done_q;

endmodule

// File: tb/tb_filter_loader_5x5.sv
// Directed-plus-random bench for filter_loader_5x5 at memory latencies 1 and 3,
// with a weight-memory model, a filter-buffer model and a reference filter model.
module tb_filter_loader_5x5;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  logic              start1 = 1'b0;
  logic [15:0]       base1  = '0;
  logic              rd_en1, read1, finish1, busy1, done1;
  logic [15:0]       addr1;
  logic signed [15:0] rdata1;
  filter5x5_t        filt1;

  logic              start3  = 1'b0;
  logic [15:0]       base3   = '0;
  logic              finish3 = 1'b0;
  logic              rd_en3, read3, busy3, done3;
  logic [15:0]       addr3;
  logic signed [15:0] rdata3;
  filter5x5_t        filt3;

  filter_loader_5x5 #(.ADDR_W(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1),
    .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rdata(rdata1),
    .read(read1), .finish(finish1), .output_filter(filt1),
    .busy(busy1), .done(done1)
  );

  filter_loader_5x5 #(.ADDR_W(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base3),
    .mem_rd_en(rd_en3), .mem_addr(addr3), .mem_rdata(rdata3),
    .read(read3), .finish(finish3), .output_filter(filt3),
    .busy(busy3), .done(done3)
  );

  // Weight memory: data for an address sampled at edge E is on the bus L cycles later;
  // junk otherwise, so any capture outside a valid slot is visible.
  shortint mem [0:65535];
  logic [15:0] pa1 = '0;
  logic        pv1 = 1'b0;
  shortint     junk1 = 16'sd0;
  logic [15:0] pa3 [3];
  logic        pv3 [3];
  shortint     junk3 = 16'sd0;

  initial begin
    for (int i = 0; i < 3; i++) begin pa3[i] = '0; pv3[i] = 1'b0; end
  end

  always @(posedge clk) begin
    pv1   <= rd_en1;
    pa1   <= addr1;
    junk1 <= shortint'($urandom);
    pv3[0] <= rd_en3; pa3[0] <= addr3;
    pv3[1] <= pv3[0]; pa3[1] <= pa3[0];
    pv3[2] <= pv3[1]; pa3[2] <= pa3[1];
    junk3 <= shortint'($urandom);
  end

  assign rdata1 = pv1    ? mem[pa1]    : junk1;
  assign rdata3 = pv3[2] ? mem[pa3[2]] : junk3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter-buffer model for dut1: finish rises 3 cycles after read rises and
  // drops 2 cycles after read falls, unless overridden by force1/fval1.
  logic force1 = 1'b0;
  logic fval1  = 1'b0;
  logic model_fin = 1'b0;
  assign finish1 = force1 ? fval1 : model_fin;

  int n_iss1 = 0, first_iss1 = 0, last_iss1 = 0;
  int rise1 = 0, rise_cnt1 = 0, fall1 = 0;
  int done_cnt1 = 0, done_cyc1 = 0;
  logic busy_at_done1 = 1'b1;
  logic [15:0] addr_log1 [$];
  int n_iss3 = 0, rise3 = 0, rise_cnt3 = 0, done_cnt3 = 0;
  int up_at = -1, down_at = -1;
  logic en_prev1 = 1'b0, rd_prev1 = 1'b0, rd_prev3 = 1'b0;

  always @(negedge clk) begin
    int n;
    n = cyc + 1;
    if (rd_en1) begin
      if (!en_prev1) first_iss1 = n;
      last_iss1 = n;
      n_iss1++;
      addr_log1.push_back(addr1);
    end
    en_prev1 = rd_en1;
    if (read1 && !rd_prev1) begin rise1 = n; rise_cnt1++; if (!force1) up_at = n + 3; end
    if (!read1 && rd_prev1) begin fall1 = n; if (!force1) down_at = n + 2; end
    rd_prev1 = read1;
    if (force1) begin
      model_fin = 1'b0; up_at = -1; down_at = -1;
    end else begin
      if (n == up_at)   model_fin = 1'b1;
      if (n == down_at) model_fin = 1'b0;
    end
    if (done1) begin done_cnt1++; done_cyc1 = n; busy_at_done1 = busy1; end
    if (rd_en3) n_iss3++;
    if (read3 && !rd_prev3) begin rise3 = n; rise_cnt3++; end
    rd_prev3 = read3;
    if (done3) done_cnt3++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic until_cyc(input int target);
    while (cyc + 1 < target) tick();
  endtask

  task automatic fill_rand(input logic [15:0] b);
    logic [15:0] a;
    for (int i = 0; i < NELEM; i++) begin
      a = b + 16'(i);
      mem[a] = shortint'($urandom);
    end
  endtask

  task automatic check_filter(input string tag, input filter5x5_t f, input logic [15:0] b);
    logic [15:0] a;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        a = b + 16'(r * K + c);
        chk($sformatf("%s[%0d][%0d]", tag, r, c), f[r][c], mem[a]);
      end
    end
  endtask

  task automatic start_1(input logic [15:0] b, output int t);
    start1 = 1'b1;
    base1  = b;
    t      = cyc + 1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic start_3(input logic [15:0] b, output int t);
    start3 = 1'b1;
    base3  = b;
    t      = cyc + 1;
    tick();
    start3 = 1'b0;
  endtask

  task automatic wait_done1(input string tag, input int d0);
    int k;
    k = 0;
    while (done_cnt1 == d0 && k < 200) begin tick(); k++; end
    chk({tag, "_done_seen"}, done_cnt1 - d0, 1);
  endtask

  task automatic wait_done3(input string tag, input int d0);
    int k;
    k = 0;
    while (done_cnt3 == d0 && k < 200) begin tick(); k++; end
    chk({tag, "_done_seen"}, done_cnt3 - d0, 1);
  endtask

  initial begin
    int t, d0, i0, a0, r0, k;
    logic [15:0] b, ea;

    for (int i = 0; i < 65536; i++) mem[i] = shortint'($urandom);
    #1 rst = 1'b1;
    tick(); tick();

    chk("rst_read", read1, 0);
    chk("rst_rd_en", rd_en1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        chk($sformatf("rst_filt[%0d][%0d]", r, c), filt1[r][c], 0);
    rst = 1'b0;
    tick(); tick();

    // Basic load with known contents, then the handshake timing
    for (int i = 0; i < NELEM; i++) mem[100 + i] = shortint'(i - 12);
    d0 = done_cnt1; i0 = n_iss1;
    start_1(16'd100, t);
    until_cyc(t + 28);
    chk("t1_issues", n_iss1 - i0, 25);
    chk("t1_first_issue", first_iss1, t + 1);
    chk("t1_last_issue", last_iss1, t + 25);
    chk("t1_read_rise", rise1, t + 27);
    chk("t1_f00", filt1[0][0], -12);
    chk("t1_f22", filt1[2][2], 0);
    chk("t1_f44", filt1[4][4], 12);
    check_filter("t1_filt", filt1, 16'd100);
    wait_done1("t2", d0);
    chk("t2_read_fall", fall1, t + 31);
    chk("t2_done_cyc", done_cyc1, t + 34);
    chk("t2_busy_at_done", busy_at_done1, 0);
    tick();
    chk("t2_done_pulse_width", done1, 0);
    chk("t2_busy_after", busy1, 0);
    check_filter("t2_filt_hold", filt1, 16'd100);

    // Address wrap at the top of memory
    fill_rand(16'hFFFE);
    a0 = addr_log1.size(); d0 = done_cnt1;
    start_1(16'hFFFE, t);
    wait_done1("t3", d0);
    chk("t3_issues", addr_log1.size() - a0, 25);
    for (int i = 0; i < NELEM; i++) begin
      ea = 16'hFFFE + 16'(i);
      chk($sformatf("t3_addr%0d", i), addr_log1[a0 + i], ea);
    end
    check_filter("t3_filt", filt1, 16'hFFFE);

    // start re-pulsed while busy is ignored
    fill_rand(16'd500);
    d0 = done_cnt1; i0 = n_iss1;
    start_1(16'd500, t);
    until_cyc(t + 5);
    start1 = 1'b1; tick(); start1 = 1'b0;
    until_cyc(t + 28);
    chk("t4_in_wait_ack", read1, 1);
    start1 = 1'b1; tick(); start1 = 1'b0;
    until_cyc(t + 45);
    chk("t4_issues", n_iss1 - i0, 25);
    chk("t4_dones", done_cnt1 - d0, 1);
    chk("t4_busy", busy1, 0);
    check_filter("t4_filt", filt1, 16'd500);

    // Reset in the middle of FETCH aborts the load
    fill_rand(16'd200);
    d0 = done_cnt1; i0 = n_iss1;
    start_1(16'd200, t);
    k = 0;
    while (n_iss1 - i0 < 10 && k < 40) begin tick(); k++; end
    chk("t5_reached_issue10", n_iss1 - i0, 10);
    rst = 1'b1;
    #1;
    chk("t5_read", read1, 0);
    chk("t5_rd_en", rd_en1, 0);
    chk("t5_busy", busy1, 0);
    chk("t5_addr", addr1, 0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        chk($sformatf("t5_zero[%0d][%0d]", r, c), filt1[r][c], 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_no_abort_done", done_cnt1 - d0, 0);
    fill_rand(16'd0);
    i0 = n_iss1;
    start_1(16'd0, t);
    wait_done1("t5", d0);
    chk("t5_new_issues", n_iss1 - i0, 25);
    check_filter("t5_filt", filt1, 16'd0);

    // Stale acknowledge held high going into PRESENT
    force1 = 1'b1; fval1 = 1'b1;
    fill_rand(16'd300);
    d0 = done_cnt1; r0 = rise_cnt1;
    start_1(16'd300, t);
    until_cyc(t + 35);
    chk("t6_no_rise", rise_cnt1 - r0, 0);
    chk("t6_read_low", read1, 0);
    chk("t6_busy", busy1, 1);
    fval1 = 1'b0;
    #1;
    chk("t6_read_rises", read1, 1);
    tick(); tick();
    fval1 = 1'b1;
    tick();
    chk("t6_read_falls", read1, 0);
    fval1 = 1'b0;
    wait_done1("t6", d0);
    force1 = 1'b0;
    check_filter("t6_filt", filt1, 16'd300);

    // Latency 3: read rises two cycles later; stale-acknowledge case repeated
    fill_rand(16'd400);
    d0 = done_cnt3; r0 = rise_cnt3; i0 = n_iss3;
    start_3(16'd400, t);
    until_cyc(t + 31);
    chk("t6b_rise_cnt", rise_cnt3 - r0, 1);
    chk("t6b_read_rise", rise3, t + 29);
    chk("t6b_read_held", read3, 1);
    chk("t6b_issues", n_iss3 - i0, 25);
    check_filter("t6b_filt", filt3, 16'd400);
    finish3 = 1'b1; tick(); tick();
    chk("t6b_read_fell", read3, 0);
    finish3 = 1'b0;
    wait_done3("t6b", d0);

    fill_rand(16'd450);
    finish3 = 1'b1;
    d0 = done_cnt3; r0 = rise_cnt3;
    start_3(16'd450, t);
    until_cyc(t + 36);
    chk("t6c_no_rise", rise_cnt3 - r0, 0);
    chk("t6c_busy", busy3, 1);
    finish3 = 1'b0;
    #1;
    chk("t6c_read_rises", read3, 1);
    tick(); tick();
    finish3 = 1'b1; tick(); tick();
    finish3 = 1'b0;
    wait_done3("t6c", d0);
    check_filter("t6c_filt", filt3, 16'd450);

    // Random bases and contents against the reference filter
    for (int it = 0; it < 3; it++) begin
      b = 16'($urandom);
      fill_rand(b);
      d0 = done_cnt1;
      start_1(b, t);
      wait_done1($sformatf("t7_%0d", it), d0);
      check_filter($sformatf("t7_%0d_filt", it), filt1, b);
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
